// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
//   stage_info_t : destination/source metadata carried by one shadow stage
//   BUBBLE       : an empty stage (all fields zero)
//   fwd_t        : E-stage ALU operand select encoding
package hazard_pkg;

  typedef struct packed {
    logic       wreg;
    logic [4:0] dst;
    logic       mem_to_reg;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
  } stage_info_t;

  localparam stage_info_t BUBBLE = '0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  // A writer hazards on a source only if it really writes a non-zero register.
  function automatic logic is_hit(input logic wreg, input logic [4:0] dst,
                                  input logic [4:0] src);
    return wreg && (dst != 5'd0) && (dst == src);
  endfunction

  // Does stage s write a register that instruction d actually reads?
  function automatic logic reads_hit(input stage_info_t s, input stage_info_t d);
    return (d.uses_rs && is_hit(s.wreg, s.dst, d.rs)) ||
           (d.uses_rt && is_hit(s.wreg, s.dst, d.rt));
  endfunction

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding selector for the E-stage ALU inputs.
//   i_src              : register number read by the E-stage instruction
//   i_m_wreg/dst/load  : M-stage writer metadata (load results are not yet
//                        available in M and cannot be forwarded from there)
//   i_w_wreg/dst       : WB-stage writer metadata
//   o_sel              : FWD_MEM, FWD_WB or FWD_RF
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned FORWARD_EN = 1
) (
  input  logic [4:0] i_src,
  input  logic       i_m_wreg,
  input  logic [4:0] i_m_dst,
  input  logic       i_m_load,
  input  logic       i_w_wreg,
  input  logic [4:0] i_w_dst,
  output fwd_t       o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (FORWARD_EN != 0) begin
      // The youngest writer (M) takes priority over WB.
      if (is_hit(i_m_wreg, i_m_dst, i_src) && !i_m_load) begin
        o_sel = FWD_MEM;
      end else if (is_hit(i_w_wreg, i_w_dst, i_src)) begin
        o_sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline.
// Tracks destination metadata of the E/M/WB instructions and produces
// forwarding selects, RAW stalls and branch/jump squashes, plus counters.
//   clk_i, reset_i          : clock, synchronous active-high reset
//   rs_id5, rt_id5, uses_*  : D-stage source registers and their use flags
//   wreg_id, dst_id5,
//   mem_to_reg_id           : D-stage destination metadata
//   pc_src_im, pc_j_im      : taken branch / jump resolved in M
//   stall_f_o, stall_d_o    : hold PC and IF/ID
//   flush_d_o/e_o/m_o       : clear IF/ID, ID/EX, EX/MEM
//   fwd_a_o2, fwd_b_o2      : E-stage operand selects
//   stall_cnt_oN            : cycles stalled
//   flush_cnt_oN            : redirects taken
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FORWARD_EN = 1,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [4:0]       rs_id5,
  input  logic [4:0]       rt_id5,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             wreg_id,
  input  logic [4:0]       dst_id5,
  input  logic             mem_to_reg_id,
  input  logic             pc_src_im,
  input  logic             pc_j_im,
  output logic             stall_f_o,
  output logic             stall_d_o,
  output logic             flush_d_o,
  output logic             flush_e_o,
  output logic             flush_m_o,
  output logic [1:0]       fwd_a_o2,
  output logic [1:0]       fwd_b_o2,
  output logic [CNT_W-1:0] stall_cnt_oN,
  output logic [CNT_W-1:0] flush_cnt_oN
);

  stage_info_t      r_s_e, r_s_m, r_s_w;
  stage_info_t      w_d_info;
  logic             w_hazard;
  logic             w_redirect;
  fwd_t             w_fwd_a, w_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  assign w_d_info = '{wreg: wreg_id, dst: dst_id5, mem_to_reg: mem_to_reg_id,
                      rs: rs_id5, rt: rt_id5,
                      uses_rs: uses_rs_id, uses_rt: uses_rt_id};

  // With forwarding only a load directly ahead must wait; without it the
  // reader waits until the writer has left WB (register file written then).
  always_comb begin
    w_hazard = 1'b0;
    if (FORWARD_EN != 0) begin
      w_hazard = r_s_e.mem_to_reg && reads_hit(r_s_e, w_d_info);
    end else begin
      w_hazard = reads_hit(r_s_e, w_d_info) || reads_hit(r_s_m, w_d_info) ||
                 reads_hit(r_s_w, w_d_info);
    end
  end

  assign w_redirect = pc_src_im | pc_j_im;

  // A redirect squashes the stalled instruction, so the PC must not hold.
  assign stall_f_o = w_hazard & ~w_redirect;
  assign stall_d_o = w_hazard & ~w_redirect;
  assign flush_d_o = w_redirect;
  assign flush_e_o = w_hazard | w_redirect;
  assign flush_m_o = w_redirect;

  fwd_sel #(.FORWARD_EN(FORWARD_EN)) u_fwd_a (
    .i_src    (r_s_e.rs),
    .i_m_wreg (r_s_m.wreg),
    .i_m_dst  (r_s_m.dst),
    .i_m_load (r_s_m.mem_to_reg),
    .i_w_wreg (r_s_w.wreg),
    .i_w_dst  (r_s_w.dst),
    .o_sel    (w_fwd_a)
  );

  fwd_sel #(.FORWARD_EN(FORWARD_EN)) u_fwd_b (
    .i_src    (r_s_e.rt),
    .i_m_wreg (r_s_m.wreg),
    .i_m_dst  (r_s_m.dst),
    .i_m_load (r_s_m.mem_to_reg),
    .i_w_wreg (r_s_w.wreg),
    .i_w_dst  (r_s_w.dst),
    .o_sel    (w_fwd_b)
  );

  assign fwd_a_o2 = w_fwd_a;
  assign fwd_b_o2 = w_fwd_b;

  // Source fields only matter in E; downstream stages just carry them along.
  logic w_unused_fields;
  assign w_unused_fields = ^{r_s_e.uses_rs, r_s_e.uses_rt,
                             r_s_m.rs, r_s_m.rt, r_s_m.uses_rs, r_s_m.uses_rt,
                             r_s_w.rs, r_s_w.rt, r_s_w.uses_rs, r_s_w.uses_rt,
                             r_s_w.mem_to_reg};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_s_e       <= BUBBLE;
      r_s_m       <= BUBBLE;
      r_s_w       <= BUBBLE;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_s_w       <= r_s_m;
      r_s_m       <= flush_m_o ? BUBBLE : r_s_e;
      r_s_e       <= (flush_e_o | stall_d_o) ? BUBBLE : w_d_info;
      r_stall_cnt <= r_stall_cnt + CNT_W'(stall_d_o);
      r_flush_cnt <= r_flush_cnt + CNT_W'(w_redirect);
    end
  end

  assign stall_cnt_oN = r_stall_cnt;
  assign flush_cnt_oN = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one forwarding instance and one
// stall-only instance share the D-stage stimulus.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_i;
  logic [4:0] rs_id5, rt_id5, dst_id5;
  logic       uses_rs_id, uses_rt_id, wreg_id, mem_to_reg_id;
  logic       pc_src_im, pc_j_im;

  logic        f1_sf, f1_sd, f1_fd, f1_fe, f1_fm;
  logic [1:0]  f1_fa, f1_fb;
  logic [31:0] f1_sc, f1_fc;
  logic        f0_sf, f0_sd, f0_fd, f0_fe, f0_fm;
  logic [1:0]  f0_fa, f0_fb;
  logic [31:0] f0_sc, f0_fc;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.FORWARD_EN(1), .CNT_W(32)) u_fwd (
    .clk_i(clk), .reset_i(reset_i),
    .rs_id5(rs_id5), .rt_id5(rt_id5),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .wreg_id(wreg_id), .dst_id5(dst_id5), .mem_to_reg_id(mem_to_reg_id),
    .pc_src_im(pc_src_im), .pc_j_im(pc_j_im),
    .stall_f_o(f1_sf), .stall_d_o(f1_sd),
    .flush_d_o(f1_fd), .flush_e_o(f1_fe), .flush_m_o(f1_fm),
    .fwd_a_o2(f1_fa), .fwd_b_o2(f1_fb),
    .stall_cnt_oN(f1_sc), .flush_cnt_oN(f1_fc)
  );

  hazard_ctrl #(.FORWARD_EN(0), .CNT_W(32)) u_nofwd (
    .clk_i(clk), .reset_i(reset_i),
    .rs_id5(rs_id5), .rt_id5(rt_id5),
    .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
    .wreg_id(wreg_id), .dst_id5(dst_id5), .mem_to_reg_id(mem_to_reg_id),
    .pc_src_im(pc_src_im), .pc_j_im(pc_j_im),
    .stall_f_o(f0_sf), .stall_d_o(f0_sd),
    .flush_d_o(f0_fd), .flush_e_o(f0_fe), .flush_m_o(f0_fm),
    .fwd_a_o2(f0_fa), .fwd_b_o2(f0_fb),
    .stall_cnt_oN(f0_sc), .flush_cnt_oN(f0_fc)
  );

  // ctl = {stall_f, stall_d, flush_d, flush_e, flush_m, fwd_a, fwd_b}
  localparam logic [10:0] C_0   = 11'b00_000_00_00;
  localparam logic [10:0] C_STL = 11'b11_010_00_00;
  localparam logic [10:0] C_RDR = 11'b00_111_00_00;
  localparam logic [10:0] C_A10 = 11'b00_000_10_00;
  localparam logic [10:0] C_W2  = 11'b00_000_01_01;
  localparam logic [10:0] C_M2  = 11'b00_000_10_10;

  typedef struct {
    string       tag;
    bit          sel;
    logic [10:0] ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t sb[$];

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] uses, input logic wr,
                       input logic [4:0] dst, input logic m2r,
                       input logic br, input logic j, input logic rst);
    @(negedge clk);
    rs_id5        = rs;
    rt_id5        = rt;
    uses_rs_id    = uses[1];
    uses_rt_id    = uses[0];
    wreg_id       = wr;
    dst_id5       = dst;
    mem_to_reg_id = m2r;
    pc_src_im     = br;
    pc_j_im       = j;
    reset_i       = rst;
  endtask

  task automatic check_front();
    exp_t        e;
    logic [10:0] o_ctl;
    logic [31:0] o_sc, o_fc;
    e = sb.pop_front();
    o_ctl = e.sel ? {f1_sf, f1_sd, f1_fd, f1_fe, f1_fm, f1_fa, f1_fb}
                  : {f0_sf, f0_sd, f0_fd, f0_fe, f0_fm, f0_fa, f0_fb};
    o_sc  = e.sel ? f1_sc : f0_sc;
    o_fc  = e.sel ? f1_fc : f0_fc;
    n_assert++;
    assert (o_ctl === e.ctl) else begin
      n_fail++;
      $error("FAIL %s ctl: observed %b expected %b", e.tag, o_ctl, e.ctl);
    end
    n_assert++;
    assert (o_sc === e.sc) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", e.tag, o_sc, e.sc);
    end
    n_assert++;
    assert (o_fc === e.fc) else begin
      n_fail++;
      $error("FAIL %s flush_cnt: observed %0d expected %0d", e.tag, o_fc, e.fc);
    end
  endtask

  task automatic step(input string tag, input bit sel,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [1:0] uses, input logic wr,
                      input logic [4:0] dst, input logic m2r,
                      input logic br, input logic j, input logic rst,
                      input logic [10:0] ctl, input logic [31:0] sc,
                      input logic [31:0] fc);
    exp_t e;
    drive(rs, rt, uses, wr, dst, m2r, br, j, rst);
    e.tag = tag; e.sel = sel; e.ctl = ctl; e.sc = sc; e.fc = fc;
    sb.push_back(e);
    #1;
    check_front();
  endtask

  task automatic do_reset();
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset_i = 1'b1; rs_id5 = '0; rt_id5 = '0; dst_id5 = '0;
    uses_rs_id = 0; uses_rt_id = 0; wreg_id = 0; mem_to_reg_id = 0;
    pc_src_im = 0; pc_j_im = 0;

    // Forwarding instance
    do_reset();
    step("fwd_reset",   1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   0, 0);
    step("add3",        1, 1, 2, 2'b11, 1, 3, 0, 0, 0, 0, C_0,   0, 0);
    step("sub_in_d",    1, 3, 5, 2'b11, 1, 4, 0, 0, 0, 0, C_0,   0, 0);
    step("sub_in_e",    1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_A10, 0, 0);
    step("drain0",      1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   0, 0);
    step("lw2",         1, 0, 2, 2'b10, 1, 2, 1, 0, 0, 0, C_0,   0, 0);
    step("lu_stall",    1, 2, 2, 2'b11, 1, 4, 0, 0, 0, 0, C_STL, 0, 0);
    step("lu_release",  1, 2, 2, 2'b11, 1, 4, 0, 0, 0, 0, C_0,   1, 0);
    step("lu_fwd_wb",   1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_W2,  1, 0);
    step("lw_r0",       1, 1, 0, 2'b10, 1, 0, 1, 0, 0, 0, C_0,   1, 0);
    step("rd_r0_d",     1, 0, 0, 2'b11, 1, 5, 0, 0, 0, 0, C_0,   1, 0);
    step("rd_r0_e",     1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   1, 0);
    step("lw6",         1, 0, 6, 2'b10, 1, 6, 1, 0, 0, 0, C_0,   1, 0);
    step("br_over_stl", 1, 6, 0, 2'b11, 1, 7, 0, 1, 0, 0, C_RDR, 1, 0);
    step("after_br",    1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   1, 1);
    step("jump",        1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, C_RDR, 1, 1);
    step("after_j",     1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   1, 2);
    step("add8a",       1, 1, 1, 2'b11, 1, 8, 0, 0, 0, 0, C_0,   1, 2);
    step("add8b",       1, 2, 2, 2'b11, 1, 8, 0, 0, 0, 0, C_0,   1, 2);
    step("sub9_d",      1, 8, 8, 2'b11, 1, 9, 0, 0, 0, 0, C_0,   1, 2);
    step("m_over_w",    1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_M2,  1, 2);
    step("drain1",      1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   1, 2);
    step("lw10",        1, 0, 10, 2'b10, 1, 10, 1, 0, 0, 0, C_0, 1, 2);
    step("no_use_rs10", 1, 10, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,  1, 2);
    step("no_fwd_ld_m", 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   1, 2);

    // Stall-only instance
    do_reset();
    step("nf_addi1",    0, 0, 1, 2'b10, 1, 1, 0, 0, 0, 0, C_0,   0, 0);
    step("nf_stall_e",  0, 1, 1, 2'b11, 1, 2, 0, 0, 0, 0, C_STL, 0, 0);
    step("nf_stall_m",  0, 1, 1, 2'b11, 1, 2, 0, 0, 0, 0, C_STL, 1, 0);
    step("nf_stall_w",  0, 1, 1, 2'b11, 1, 2, 0, 0, 0, 0, C_STL, 2, 0);
    step("nf_release",  0, 1, 1, 2'b11, 1, 2, 0, 0, 0, 0, C_0,   3, 0);
    step("nf_in_e",     0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   3, 0);

    // Reset in the middle of hazard traffic
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    step("rs_lw2",      1, 0, 2, 2'b10, 1, 2, 1, 0, 0, 0, C_0,   0, 0);
    step("rs_stall",    1, 2, 2, 2'b11, 1, 4, 0, 0, 0, 0, C_STL, 0, 0);
    step("rs_lw2_rst",  1, 0, 2, 2'b10, 1, 2, 1, 0, 0, 1, C_0,   1, 0);
    step("rs_stale_ld", 1, 2, 2, 2'b11, 1, 4, 0, 0, 0, 0, C_0,   0, 0);
    step("rs_br_rst",   1, 0, 0, 2'b00, 0, 0, 0, 1, 0, 1, C_RDR, 0, 0);
    step("rs_after",    1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, C_0,   0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
